btn_counter_ctrl: RTL



---
 rtl/btn_counter_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/btn_counter_ctrl.sv
// Up/down counter controller for the four-button board: press pulses step the counter,
// holding inc/dec auto-repeats, a wrap-around fires a one-cycle pulse and a retriggerable beep.
// LEDs show the count in binary (COUNT mode) or as a single running light (RUN mode).
module btn_counter_ctrl #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned BEEP_CYCLES   = 2_500_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       i_flag_btn_down,
  input  logic [3:0]       i_btn_held,
  output logic [3:0]       o_leds,
  output logic [WIDTH-1:0] o_count,
  output logic             o_mode,
  output logic             o_wrap,
  output logic             o_beep
);

  localparam int unsigned CntMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  // cnt only ever holds 0..CntMax-1
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned BeepW  = $clog2(BEEP_CYCLES + 1);

  localparam logic [CntW-1:0]  HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]  RptLast  = CntW'(REPEAT_CYCLES - 1);
  localparam logic [BeepW-1:0] BeepLoad = BeepW'(BEEP_CYCLES);
  localparam logic [WIDTH-1:0] CountMax = '1;

  typedef enum logic [1:0] {StIdle, StWait, StRpt} state_e;

  state_e           state_q;
  logic             dir_q;      // 0 = inc, 1 = dec
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] count_q;
  logic             mode_q;
  logic             wrap_q;
  logic [BeepW-1:0] beep_q;

  logic             btn_inc, btn_dec, btn_clr, btn_mode;
  logic             idle_force, press, held_dir, released, tick;
  logic             step_en, step_dir, step_wrap;
  logic [WIDTH-1:0] count_step;
  logic [3:0]       count_lo;

  // Bits 3:2 of the held levels carry no repeat behaviour.
  logic unused_held;
  assign unused_held = ^i_btn_held[3:2];

  // Decode presses, repeat ticks and the single step allowed per cycle.
  always_comb begin
    btn_inc    = i_flag_btn_down[0];
    btn_dec    = i_flag_btn_down[1];
    btn_clr    = i_flag_btn_down[2];
    btn_mode   = i_flag_btn_down[3];
    idle_force = btn_clr | btn_mode | (btn_inc & btn_dec);
    press      = ~idle_force & (btn_inc | btn_dec);
    held_dir   = dir_q ? i_btn_held[1] : i_btn_held[0];
    // First WAIT cycle (cnt==0) skips the release check: held may lag its pulse by a cycle.
    released   = ((state_q == StWait) && (cnt_q != '0) && ~held_dir) ||
                 ((state_q == StRpt) && ~held_dir);
    tick       = ~released && (((state_q == StWait) && (cnt_q == HoldLast)) ||
                               ((state_q == StRpt) && (cnt_q == RptLast)));
    // A press wins over a tick in the same cycle.
    step_en    = press | (tick & ~idle_force & ~(btn_inc | btn_dec));
    step_dir   = press ? btn_dec : dir_q;
    step_wrap  = step_dir ? (count_q == '0) : (count_q == CountMax);
    count_step = step_dir ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
  end

  // Counter, mode, wrap pulse and auto-repeat FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= step_en & step_wrap;

      if (btn_clr) begin
        count_q <= '0;
      end else if (step_en) begin
        count_q <= count_step;
      end

      if (btn_mode && !btn_clr) begin
        mode_q <= ~mode_q;
      end

      if (idle_force) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else if (press) begin
        state_q <= StWait;
        dir_q   <= btn_dec;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            cnt_q <= '0;
          end
          StWait: begin
            if (released) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (cnt_q == HoldLast) begin
              state_q <= StRpt;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StRpt: begin
            if (released) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (cnt_q == RptLast) begin
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // Beep length counter; a wrap (re)loads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beep_q <= '0;
    end else if (step_en && step_wrap) begin
      beep_q <= BeepLoad;
    end else if (beep_q != '0) begin
      beep_q <= beep_q - BeepW'(1);
    end
  end

  // Low four count bits, zero-extended for narrow counters.
  if (WIDTH >= 4) begin : g_lo_wide
    assign count_lo = count_q[3:0];
  end else begin : g_lo_narrow
    assign count_lo = {{(4 - WIDTH){1'b0}}, count_q};
  end

  // Output decodes of the registered state.
  always_comb begin
    o_count = count_q;
    o_mode  = mode_q;
    o_wrap  = wrap_q;
    o_beep  = (beep_q != '0);
    o_leds  = mode_q ? (4'b0001 << count_q[1:0]) : count_lo;
  end

endmodule
